obi_bus_monitor: RTL

Passive, parametrised OBI bus monitor placed alongside any master/slave pair in the hsid_x OBI memory subsystem, usually between the accelerator's OBI master port and the memory model in testbenches and debug builds. It observes `obi_req`/`obi_rsp` without driving the bus and maintains saturating read/write transaction counters, an outstanding-transaction count and sticky protocol-error flags. It optionally holds a pop-able trace FIFO of completed transactions, each entry carrying its address, direction and data.

---
 rtl/obi_bus_monitor.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/obi_bus_monitor.sv
// obi_bus_monitor: passive observer of an OBI request/response pair.
// Counts accepted reads/writes (saturating), tracks outstanding transactions,
// raises sticky protocol-error flags and, when OBI_MON_TRACE_EN is defined,
// keeps a pending queue plus a pop-able trace FIFO of completed transactions.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   obi_req, obi_rsp    observed bus (never driven)
//   clear_i             sync clear of counters and error flags
//   rd_cnt_o, wr_cnt_o  accepted read/write counts
//   outstanding_o       accepted-but-unanswered count
//   err_o               sticky errors {trace ovf, unstable req, outst ovf, unexpected rvalid}
//   trace_pop_i         pop trace head
//   trace_valid_o, trace_we_o, trace_addr_o, trace_data_o   trace head entry
// Optional feature macro: OBI_MON_TRACE_EN

package hsid_x_obi_inf_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Pending-queue and trace entry; data holds wdata while pending.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } obi_trace_t;

endpackage

module obi_bus_monitor #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned TRACE_DEPTH     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  hsid_x_obi_inf_pkg::obi_req_t           obi_req,
  input  hsid_x_obi_inf_pkg::obi_resp_t          obi_rsp,
  input  logic                                   clear_i,
  output logic [CNT_W-1:0]                       rd_cnt_o,
  output logic [CNT_W-1:0]                       wr_cnt_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic [3:0]                             err_o,
  input  logic                                   trace_pop_i,
  output logic                                   trace_valid_o,
  output logic                                   trace_we_o,
  output logic [31:0]                            trace_addr_o,
  output logic [31:0]                            trace_data_o
);

  import hsid_x_obi_inf_pkg::*;

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SIG_W = 1 + 4 + 32 + 32;

  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [3:0]       err_q;
  logic [SIG_W-1:0] req_sig, prev_sig_q;
  logic             stall_q;
  logic             accept, rsp_ok, q_push;
  logic             err_unexp, err_ovf, err_unstable, err_trace;

  // Bus event decode; a completion only counts if something is outstanding.
  assign accept    = obi_req.req & obi_rsp.gnt;
  assign rsp_ok    = obi_rsp.rvalid & (outstanding_q != '0);
  assign err_unexp = obi_rsp.rvalid & (outstanding_q == '0);
  assign err_ovf   = accept & (outstanding_q == OUT_W'(MAX_OUTSTANDING)) & ~rsp_ok;
  assign q_push    = accept & ~err_ovf;

  // A stalled request must be held unchanged until granted.
  assign req_sig      = {obi_req.we, obi_req.be, obi_req.addr, obi_req.wdata};
  assign err_unstable = stall_q & (~obi_req.req | (req_sig != prev_sig_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q    <= 1'b0;
      prev_sig_q <= '0;
    end else begin
      stall_q    <= obi_req.req & ~obi_rsp.gnt;
      prev_sig_q <= req_sig;
    end
  end

  // Outstanding count: same-cycle accept and completion cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({q_push, rsp_ok})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Saturating counters and sticky errors; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      err_q         <= '0;
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (clear_i) begin
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
        err_q    <= '0;
      end else begin
        if (accept && obi_req.we && (wr_cnt_q != '1))  wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        if (accept && !obi_req.we && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        err_q <= err_q | {err_trace, err_unstable, err_ovf, err_unexp};
      end
    end
  end

  assign rd_cnt_o      = rd_cnt_q;
  assign wr_cnt_o      = wr_cnt_q;
  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

`ifdef OBI_MON_TRACE_EN

  localparam int unsigned PIW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned TW  = $clog2(TRACE_DEPTH);

  obi_trace_t       pend_mem [MAX_OUTSTANDING];
  logic [PIW-1:0]   pend_wr_q, pend_rd_q;
  obi_trace_t       pend_head, tr_new;

  obi_trace_t       tr_mem [TRACE_DEPTH];
  logic [TW:0]      tr_wr_q, tr_rd_q, tr_wr_d, tr_rd_d;
  logic             tr_empty, tr_full, tr_pop, tr_push;
  obi_trace_t       head_q, head_d;
  logic             valid_q;

  // Pending queue: occupancy is outstanding_q, so indices need no wrap bit.
  always_ff @(posedge clk) begin
    if (q_push) pend_mem[pend_wr_q] <= '{we: obi_req.we, addr: obi_req.addr, data: obi_req.wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_wr_q <= '0;
      pend_rd_q <= '0;
    end else begin
      if (q_push) pend_wr_q <= (pend_wr_q == PIW'(MAX_OUTSTANDING - 1)) ? '0 : pend_wr_q + PIW'(1);
      if (rsp_ok) pend_rd_q <= (pend_rd_q == PIW'(MAX_OUTSTANDING - 1)) ? '0 : pend_rd_q + PIW'(1);
    end
  end

  assign pend_head = pend_mem[pend_rd_q];
  assign tr_new    = '{we:   pend_head.we,
                       addr: pend_head.addr,
                       data: pend_head.we ? pend_head.data : obi_rsp.rdata};

  // Trace FIFO: wrap-bit pointers; a same-cycle pop frees room for the push.
  assign tr_empty  = (tr_wr_q == tr_rd_q);
  assign tr_full   = (tr_wr_q[TW] != tr_rd_q[TW]) && (tr_wr_q[TW-1:0] == tr_rd_q[TW-1:0]);
  assign tr_pop    = trace_pop_i & ~tr_empty;
  assign tr_push   = rsp_ok & (~tr_full | tr_pop);
  assign err_trace = rsp_ok & tr_full & ~tr_pop;
  assign tr_wr_d   = tr_wr_q + (TW+1)'(tr_push);
  assign tr_rd_d   = tr_rd_q + (TW+1)'(tr_pop);

  // Registered head: bypass the new entry when it lands at the next read slot.
  always_comb begin
    head_d = '0;
    if (tr_wr_d != tr_rd_d) begin
      if (tr_push && (tr_wr_q[TW-1:0] == tr_rd_d[TW-1:0])) head_d = tr_new;
      else                                                 head_d = tr_mem[tr_rd_d[TW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (tr_push) tr_mem[tr_wr_q[TW-1:0]] <= tr_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_wr_q <= '0;
      tr_rd_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tr_wr_q <= tr_wr_d;
      tr_rd_q <= tr_rd_d;
      head_q  <= head_d;
      valid_q <= (tr_wr_d != tr_rd_d);
    end
  end

  assign trace_valid_o = valid_q;
  assign trace_we_o    = head_q.we;
  assign trace_addr_o  = head_q.addr;
  assign trace_data_o  = head_q.data;

`else

  logic unused_trace;

  assign err_trace     = 1'b0;
  assign unused_trace  = ^{trace_pop_i, obi_rsp.rdata};
  assign trace_valid_o = 1'b0;
  assign trace_we_o    = 1'b0;
  assign trace_addr_o  = '0;
  assign trace_data_o  = '0;

`endif

endmodule
